prefetcher_block_queue: RTL and testbench



---
 rtl/prefetcher_pkg.sv | 24 ++
 rtl/pr_addr_match.sv | 42 ++++
 rtl/prefetcher_block_queue.sv | 201 ++++++++++++++++++++
 tb/tb_prefetcher_block_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher: opcodes, per-entry status flags
// and a saturating counter helper.
package prefetcher_pkg;

  typedef enum logic [2:0] {
    NOP               = 3'd0,
    READ_REQ_PREF     = 3'd1,
    READ_REQ_MASTER   = 3'd2,
    READ_DATA_SLAVE   = 3'd3,
    READ_DATA_PROMISE = 3'd4
  } pr_opcode_e;

  typedef struct packed {
    logic valid;
    logic promised;
    logic drop;
    logic done;
  } pr_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pr_addr_match.sv
// Parallel address/len compare over all queue entries with
// oldest-first priority select relative to the head pointer.
module pr_addr_match #(
  parameter int LQ = 6,
  parameter int AW = 64,
  parameter int LW = 8
) (
  input  logic [(1<<LQ)-1:0]         cand,
  input  logic [(1<<LQ)-1:0][AW-1:0] addrs,
  input  logic [(1<<LQ)-1:0][LW-1:0] lens,
  input  logic [LQ-1:0]              head,
  input  logic [AW-1:0]              addr,
  input  logic [LW-1:0]              len,
  output logic                       hit,
  output logic [LQ-1:0]              idx
);

  localparam int QN = 1 << LQ;

  logic [QN-1:0] match;
  logic [LQ-1:0] j;

  always_comb begin
    for (int i = 0; i < QN; i++)
      match[i] = cand[i] && addrs[i] == addr && lens[i] == len;
  end

  // Walk youngest to oldest so the oldest match is assigned last.
  always_comb begin
    hit = 1'b0;
    idx = head;
    j   = '0;
    for (int k = QN - 1; k >= 0; k--) begin
      j = head + LQ'(k);
      if (match[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/prefetcher_block_queue.sv
// Prefetcher block queue: burst storage, hit lookup, beat streaming.
// Optional PR_QUEUE_STATS_EN adds hit/miss/drop counters.
module prefetcher_block_queue
  import prefetcher_pkg::*;
#(
  parameter int ADDR_BITS          = 64,
  parameter int DATA_WIDTH         = 64,
  parameter int LOG_QUEUE_SIZE     = 6,
  parameter int LOG_BEATS          = 3,
  parameter int BURST_LEN_WIDTH    = 8,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       pr_flush,
  input  logic [2:0]                 pr_opCode,
  input  logic [ADDR_BITS-1:0]       pr_m_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] pr_m_ar_len,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  output logic                       pr_addrHit,
  output logic                       pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]    pr_reqCnt,
  output logic                       pr_almostFull,
  output logic                       pr_r_valid,
  output logic [DATA_WIDTH-1:0]      s_r_data,
  output logic                       s_r_last,
  output logic                       pr_overflow
`ifdef PR_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_hit,
  output logic [31:0]                stat_miss,
  output logic [31:0]                stat_drop
`endif
);

  localparam int LQ = LOG_QUEUE_SIZE;
  localparam int QN = 1 << LQ;
  localparam int BN = 1 << LOG_BEATS;
  localparam int BW = LOG_BEATS + 1;
  localparam int LW = BURST_LEN_WIDTH;

  typedef logic [LQ-1:0] ptr_t;

  pr_entry_t                    ent [QN];
  logic [QN-1:0][ADDR_BITS-1:0] addr_q;
  logic [QN-1:0][LW-1:0]        len_q;
  logic [BW-1:0]                wr_q [QN];
  logic [BW-1:0]                rd_q [QN];
  logic [DATA_WIDTH-1:0]        mem [QN][BN];

  ptr_t        head, fill, tail;
  logic [LQ:0] cnt;
  logic        ovf;

  pr_opcode_e    op;
  logic [QN-1:0] cand, older;
  logic          hit;
  ptr_t          hit_idx, hit_age;
  logic          full, is_pref, is_mstr, is_slv, is_prom;
  logic          req_alloc, do_alloc, do_promise;
  logic          do_wr, wr_last, do_rd, rd_last;
  logic          r_valid, auto_drop, pop, outstanding;

  always_comb begin
    for (int i = 0; i < QN; i++)
      cand[i] = ent[i].valid & ~ent[i].promised & ~ent[i].drop;
  end

  pr_addr_match #(
    .LQ (LQ),
    .AW (ADDR_BITS),
    .LW (LW)
  ) u_match (
    .cand  (cand),
    .addrs (addr_q),
    .lens  (len_q),
    .head  (head),
    .addr  (pr_m_ar_addr),
    .len   (pr_m_ar_len),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign op      = pr_opcode_e'(pr_opCode);
  assign full    = cnt == (LQ+1)'(QN);
  assign is_pref = op == READ_REQ_PREF;
  assign is_mstr = op == READ_REQ_MASTER;
  assign is_slv  = op == READ_DATA_SLAVE;
  assign is_prom = op == READ_DATA_PROMISE;

  assign req_alloc  = is_pref | (is_mstr & ~hit);
  assign do_alloc   = req_alloc & ~full;
  assign do_promise = is_mstr & hit;

  assign do_wr   = is_slv & ent[fill].valid & ~ent[fill].done;
  assign wr_last = LW'(wr_q[fill]) == len_q[fill];

  assign r_valid = ent[head].valid & ent[head].promised
                 & (rd_q[head] < wr_q[head]);
  assign rd_last = LW'(rd_q[head]) == len_q[head];
  assign do_rd   = is_prom & r_valid;

  assign auto_drop = ent[head].valid & ent[head].drop & ent[head].done;
  assign pop       = (do_rd & rd_last) | auto_drop;

  // Age relative to head decides which entries are older than the hit.
  assign hit_age = ptr_t'(hit_idx - head);
  always_comb begin
    for (int j = 0; j < QN; j++)
      older[j] = ptr_t'(ptr_t'(j) - head) < hit_age;
  end

  always_comb begin
    outstanding = 1'b0;
    for (int i = 0; i < QN; i++)
      outstanding |= ent[i].valid & ~ent[i].done;
  end

  always_ff @(posedge clk) begin
    if (!resetN || pr_flush) begin
      for (int i = 0; i < QN; i++) begin
        ent[i]    <= '0;
        addr_q[i] <= '0;
        len_q[i]  <= '0;
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
      end
      head <= '0;
      fill <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      ovf <= req_alloc & full;
      if (do_alloc) begin
        ent[tail]    <= '{valid: 1'b1, promised: is_mstr,
                          drop: 1'b0, done: 1'b0};
        addr_q[tail] <= pr_m_ar_addr;
        len_q[tail]  <= pr_m_ar_len;
        wr_q[tail]   <= '0;
        rd_q[tail]   <= '0;
        tail         <= tail + ptr_t'(1);
      end
      if (do_promise) begin
        ent[hit_idx].promised <= 1'b1;
        for (int j = 0; j < QN; j++)
          if (older[j] && ent[j].valid && !ent[j].promised)
            ent[j].drop <= 1'b1;
      end
      if (do_wr) begin
        wr_q[fill] <= wr_q[fill] + BW'(1);
        if (wr_last) begin
          ent[fill].done <= 1'b1;
          fill           <= fill + ptr_t'(1);
        end
      end
      if (do_rd)
        rd_q[head] <= rd_q[head] + BW'(1);
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + ptr_t'(1);
      end
      cnt <= cnt + (LQ+1)'(do_alloc) - (LQ+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (resetN && !pr_flush && do_wr)
      mem[fill][wr_q[fill][LOG_BEATS-1:0]] <= m_r_data;
  end

`ifdef PR_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stat_hit  <= '0;
      stat_miss <= '0;
      stat_drop <= '0;
    end else if (!pr_flush) begin
      if (do_promise)
        stat_hit <= sat_inc(stat_hit);
      if (is_mstr && !hit)
        stat_miss <= sat_inc(stat_miss);
      if (auto_drop)
        stat_drop <= sat_inc(stat_drop);
    end
  end
`endif

  assign pr_addrHit        = hit;
  assign pr_hasOutstanding = outstanding;
  assign pr_reqCnt         = cnt;
  assign pr_almostFull     = ((LQ+1)'(QN) - cnt)
                           <= (LQ+1)'(ALMOST_FULL_MARGIN);
  assign pr_r_valid        = r_valid;
  assign s_r_data          = r_valid
                           ? mem[head][rd_q[head][LOG_BEATS-1:0]]
                           : '0;
  assign s_r_last          = r_valid & rd_last;
  assign pr_overflow       = ovf;

endmodule

// File: tb/tb_prefetcher_block_queue.sv
// Directed bench for prefetcher_block_queue: lookup, fill, stream,
// drop, full/overflow, flush and pointer wrap.
module tb_prefetcher_block_queue;
  import prefetcher_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        pr_flush;
  logic [2:0]  pr_opCode;
  logic [63:0] pr_m_ar_addr;
  logic [7:0]  pr_m_ar_len;
  logic [63:0] m_r_data;
  logic        pr_addrHit;
  logic        pr_hasOutstanding;
  logic [6:0]  pr_reqCnt;
  logic        pr_almostFull;
  logic        pr_r_valid;
  logic [63:0] s_r_data;
  logic        s_r_last;
  logic        pr_overflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prefetcher_block_queue u_dut (
    .clk               (clk),
    .resetN            (resetN),
    .pr_flush          (pr_flush),
    .pr_opCode         (pr_opCode),
    .pr_m_ar_addr      (pr_m_ar_addr),
    .pr_m_ar_len       (pr_m_ar_len),
    .m_r_data          (m_r_data),
    .pr_addrHit        (pr_addrHit),
    .pr_hasOutstanding (pr_hasOutstanding),
    .pr_reqCnt         (pr_reqCnt),
    .pr_almostFull     (pr_almostFull),
    .pr_r_valid        (pr_r_valid),
    .s_r_data          (s_r_data),
    .s_r_last          (s_r_last),
    .pr_overflow       (pr_overflow)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] a,
                       input logic [7:0] l, input logic [63:0] d);
    @(negedge clk);
    pr_flush     = 1'b0;
    pr_opCode    = op;
    pr_m_ar_addr = a;
    pr_m_ar_len  = l;
    m_r_data     = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [2:0] op, input logic [63:0] a,
                     input logic [7:0] l, input logic [63:0] d);
    drive(op, a, l, d);
    tick();
  endtask

  initial begin
    logic [63:0] dv;
    resetN = 1'b0;
    pr_flush = 1'b0;
    pr_opCode = 3'd0;
    pr_m_ar_addr = '0;
    pr_m_ar_len = '0;
    m_r_data = '0;
    cyc(NOP, 0, 0, 0);
    cyc(NOP, 0, 0, 0);
    check("rst_hit",  pr_addrHit, 0);
    check("rst_out",  pr_hasOutstanding, 0);
    check("rst_cnt",  pr_reqCnt, 0);
    check("rst_af",   pr_almostFull, 0);
    check("rst_rv",   pr_r_valid, 0);
    check("rst_last", s_r_last, 0);
    check("rst_ovf",  pr_overflow, 0);
    check("rst_data", s_r_data, 0);
    @(negedge clk);
    resetN = 1'b1;
    cyc(NOP, 0, 0, 0);
    check("nop_cnt", pr_reqCnt, 0);

    // prefetch then demand hit, stream four beats
    cyc(READ_REQ_PREF, 64'h1000, 3, 0);
    check("pf_cnt", pr_reqCnt, 1);
    check("pf_out", pr_hasOutstanding, 1);
    drive(READ_REQ_MASTER, 64'h1000, 3, 0);
    check("m_hit", pr_addrHit, 1);
    tick();
    check("m_cnt", pr_reqCnt, 1);
    check("m_rv0", pr_r_valid, 0);
    for (int b = 0; b < 4; b++) begin
      cyc(READ_DATA_SLAVE, 0, 0, 64'hD0 + 64'(b));
      check("w_rv", pr_r_valid, 1);
      check("w_d0", s_r_data, 64'hD0);
    end
    check("w_out", pr_hasOutstanding, 0);
    for (int b = 0; b < 4; b++) begin
      check("r_rv", pr_r_valid, 1);
      check("r_data", s_r_data, 64'hD0 + 64'(b));
      check("r_last", s_r_last, (b == 3) ? 1 : 0);
      cyc(READ_DATA_PROMISE, 0, 0, 0);
    end
    check("r_cnt", pr_reqCnt, 0);
    check("r_rv_end", pr_r_valid, 0);

    // hit on third prefetch drops the two older ones
    cyc(READ_REQ_PREF, 64'h1000, 0, 0);
    cyc(READ_REQ_PREF, 64'h1040, 0, 0);
    cyc(READ_REQ_PREF, 64'h1080, 0, 0);
    check("d_cnt3", pr_reqCnt, 3);
    drive(READ_REQ_MASTER, 64'h1080, 0, 0);
    check("d_hit", pr_addrHit, 1);
    tick();
    check("d_cnt_h", pr_reqCnt, 3);
    drive(NOP, 64'h1000, 0, 0);
    check("d_nohit", pr_addrHit, 0);
    tick();
    cyc(READ_DATA_SLAVE, 0, 0, 64'hA0);
    check("d_cnt_b1", pr_reqCnt, 3);
    check("d_rv_b1", pr_r_valid, 0);
    cyc(READ_DATA_SLAVE, 0, 0, 64'hA1);
    check("d_cnt_b2", pr_reqCnt, 2);
    cyc(READ_DATA_SLAVE, 0, 0, 64'hA2);
    check("d_cnt_b3", pr_reqCnt, 1);
    check("d_rv", pr_r_valid, 1);
    check("d_data", s_r_data, 64'hA2);
    check("d_last", s_r_last, 1);
    cyc(READ_DATA_PROMISE, 0, 0, 0);
    check("d_cnt0", pr_reqCnt, 0);

    // duplicate prefetches: demand must promise the older one
    cyc(READ_REQ_PREF, 64'h2000, 0, 0);
    cyc(READ_REQ_PREF, 64'h2000, 0, 0);
    cyc(READ_REQ_MASTER, 64'h2000, 0, 0);
    check("o_cnt", pr_reqCnt, 2);
    cyc(READ_DATA_SLAVE, 0, 0, 64'hB0);
    check("o_rv", pr_r_valid, 1);
    check("o_data", s_r_data, 64'hB0);

    // flush with concurrent op 1
    cyc(READ_REQ_PREF, 64'h3000, 3, 0);
    cyc(READ_REQ_PREF, 64'h3040, 3, 0);
    check("f_cnt4", pr_reqCnt, 4);
    check("f_out1", pr_hasOutstanding, 1);
    drive(READ_REQ_PREF, 64'h5000, 0, 0);
    pr_flush = 1'b1;
    tick();
    check("f_cnt", pr_reqCnt, 0);
    check("f_out", pr_hasOutstanding, 0);
    check("f_rv", pr_r_valid, 0);
    cyc(READ_DATA_SLAVE, 0, 0, 64'hDEAD);
    check("f_drop_rv", pr_r_valid, 0);
    check("f_drop_cnt", pr_reqCnt, 0);
    cyc(READ_REQ_MASTER, 64'h3000, 3, 0);
    check("f_miss_cnt", pr_reqCnt, 1);
    check("f_miss_rv", pr_r_valid, 0);
    drive(NOP, 0, 0, 0);
    pr_flush = 1'b1;
    tick();

    // fill to capacity, then overflow
    for (int i = 0; i < 64; i++) begin
      cyc(READ_REQ_PREF, 64'h10000 + 64'(i) * 64, 0, 0);
      if (i == 60) check("af_61", pr_almostFull, 0);
      if (i == 61) check("af_62", pr_almostFull, 1);
    end
    check("full_cnt", pr_reqCnt, 64);
    check("full_ovf0", pr_overflow, 0);
    drive(NOP, 64'h10000 + 5 * 64, 0, 0);
    check("full_hit", pr_addrHit, 1);
    tick();
    cyc(READ_REQ_PREF, 64'h90000, 0, 0);
    check("ovf", pr_overflow, 1);
    check("ovf_cnt", pr_reqCnt, 64);
    drive(NOP, 64'h90000, 0, 0);
    check("ovf_nohit", pr_addrHit, 0);
    tick();
    check("ovf_pulse", pr_overflow, 0);
    drive(NOP, 0, 0, 0);
    pr_flush = 1'b1;
    tick();
    check("full_flush", pr_reqCnt, 0);

    // stream across pointer wrap
    for (int i = 0; i < 70; i++) begin
      dv = 64'hA500_0000_0000_0000 | (64'(i) << 8);
      cyc(READ_REQ_MASTER, 64'h40000 + 64'(i) * 64, 1, 0);
      cyc(READ_DATA_SLAVE, 0, 0, dv);
      cyc(READ_DATA_SLAVE, 0, 0, dv | 64'h1);
      check("wr_d0", s_r_data, dv);
      cyc(READ_DATA_PROMISE, 0, 0, 0);
      check("wr_d1", s_r_data, dv | 64'h1);
      check("wr_l1", s_r_last, 1);
      cyc(READ_DATA_PROMISE, 0, 0, 0);
    end
    check("wr_cnt", pr_reqCnt, 0);
    check("wr_rv", pr_r_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
